// File: rtl/seq_feeder_pkg.sv
// Shared alignment package: array geometry, base encoding, feeder states,
// score width and the negative-infinity score used by the PE array.
package seq_feeder_pkg;

   localparam int unsigned PE_NUM  = 64;               // PEs; query length in bases
   localparam int unsigned MAX_REF = 256;              // max reference bases, multiple of 4
   localparam int unsigned LEN_W   = 9;                // reference-length field, holds MAX_REF
   localparam int unsigned B_W     = 2 * PE_NUM;       // parallel query bus
   localparam int unsigned QBYTES  = PE_NUM / 4;       // query bytes per job
   localparam int unsigned QIDX_W  = $clog2(QBYTES);
   localparam int unsigned BCNT_W  = LEN_W - 2;        // byte counter
   localparam int unsigned FLUSH_W = $clog2(PE_NUM);   // flush counter
   localparam int unsigned RADDR_W = $clog2(MAX_REF);  // base address
   localparam int unsigned WADDR_W = $clog2(MAX_REF / 4); // byte address
   localparam int unsigned SCORE_W = 14;

   localparam logic [1:0] BASE_A = 2'b00;
   localparam logic [1:0] BASE_C = 2'b01;
   localparam logic [1:0] BASE_G = 2'b10;
   localparam logic [1:0] BASE_T = 2'b11;

   localparam logic [SCORE_W-1:0] NEG_INF = 14'b10000000000000;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_Q,
      LOAD_R,
      STREAM,
      FLUSH,
      DONE
   } state_t;

endpackage

// File: rtl/seq_feeder_if.sv
// Job command and byte-stream handshake between the job source (master)
// and the feeder (slave).
//   i_cmd_valid / o_cmd_ready / i_ref_len : job command
//   i_in_valid  / o_in_ready  / i_in_data : query then reference bytes
interface seq_feeder_if;
   import seq_feeder_pkg::*;

   logic             i_cmd_valid;
   logic             o_cmd_ready;
   logic [LEN_W-1:0] i_ref_len;
   logic             i_in_valid;
   logic             o_in_ready;
   logic [7:0]       i_in_data;

   modport master (
      output i_cmd_valid, i_ref_len, i_in_valid, i_in_data,
      input  o_cmd_ready, o_in_ready
   );

   modport slave (
      input  i_cmd_valid, i_ref_len, i_in_valid, i_in_data,
      output o_cmd_ready, o_in_ready
   );

endinterface

// File: rtl/seq_feeder_ref_base_buffer.sv
// Reference base store: MAX_REF x 2-bit, 4-base byte write, 1-base read.
//   i_clk, i_rst        : clock, async active-high reset (read register only)
//   i_we, i_waddr, i_wdata : write one byte (bases 4a..4a+3)
//   i_re, i_raddr       : read one base
//   o_rdata             : registered read data, A when i_re was low
module seq_feeder_ref_base_buffer
   import seq_feeder_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_we,
   input  logic [WADDR_W-1:0] i_waddr,
   input  logic [7:0]         i_wdata,
   input  logic               i_re,
   input  logic [RADDR_W-1:0] i_raddr,
   output logic [1:0]         o_rdata
);

   logic [1:0] mem [MAX_REF];

   // Byte write scatters four bases into consecutive base slots.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int j = 0; j < 4; j++) begin
            mem[{i_waddr, 2'(j)}] <= i_wdata[2*j +: 2];
         end
      end
   end

   // Reads of the byte being written in the same cycle take the new data,
   // so ref[0] can be prefetched while its byte is still arriving.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_rdata <= BASE_A;
      end else if (!i_re) begin
         o_rdata <= BASE_A;
      end else if (i_we && (i_waddr == i_raddr[RADDR_W-1:2])) begin
         o_rdata <= i_wdata[{i_raddr[1:0], 1'b0} +: 2];
      end else begin
         o_rdata <= mem[i_raddr];
      end
   end

endmodule

// File: rtl/seq_feeder.sv
// Upstream feeder of the PE alignment array: takes one job (command, query
// bytes, reference bytes), drives the parallel query bus, streams the
// reference one base per cycle and frames the run with start/stop pulses.
//   i_clk, i_rst : clock, async active-high reset
//   bus          : command and byte-stream handshake (slave side)
//   o_start/o_stop : one-cycle array framing pulses
//   o_B          : query bases, o_A : current reference base
//   o_busy, o_done, o_err : job status
module seq_feeder
   import seq_feeder_pkg::*;
(
   input  logic           i_clk,
   input  logic           i_rst,
   seq_feeder_if.slave    bus,
   output logic           o_start,
   output logic           o_stop,
   output logic [B_W-1:0] o_B,
   output logic [1:0]     o_A,
   output logic           o_busy,
   output logic           o_done,
   output logic           o_err
);

   state_t              state;
   logic [LEN_W-1:0]    last_base;
   logic [BCNT_W-1:0]   last_byte;
   logic [BCNT_W-1:0]   byte_cnt;
   logic [LEN_W-1:0]    base_idx;
   logic [FLUSH_W-1:0]  flush_cnt;

   logic                cmd_fire;
   logic                in_fire;
   logic                len_ok;
   logic                buf_we;
   logic                buf_re;
   logic [RADDR_W-1:0]  buf_raddr;

   assign cmd_fire = bus.i_cmd_valid & bus.o_cmd_ready;
   assign in_fire  = bus.i_in_valid & bus.o_in_ready;
   assign len_ok   = (bus.i_ref_len != '0) && (bus.i_ref_len <= LEN_W'(MAX_REF));

   // Buffer control: write ref bytes; read one base ahead of the stream,
   // starting with ref[0] on the final reference byte.
   always_comb begin
      buf_we    = 1'b0;
      buf_re    = 1'b0;
      buf_raddr = '0;
      if (state == LOAD_R) begin
         buf_we = in_fire;
         buf_re = in_fire && (byte_cnt == last_byte);
      end else if (state == STREAM) begin
         buf_re    = (base_idx != last_base);
         buf_raddr = RADDR_W'(base_idx + LEN_W'(1));
      end
   end

   seq_feeder_ref_base_buffer u_ref_buf (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (buf_we),
      .i_waddr (WADDR_W'(byte_cnt)),
      .i_wdata (bus.i_in_data),
      .i_re    (buf_re),
      .i_raddr (buf_raddr),
      .o_rdata (o_A)
   );

   // Job sequencer with registered handshake, framing and status outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state           <= IDLE;
         last_base       <= '0;
         last_byte       <= '0;
         byte_cnt        <= '0;
         base_idx        <= '0;
         flush_cnt       <= '0;
         o_B             <= '0;
         o_start         <= 1'b0;
         o_stop          <= 1'b0;
         o_busy          <= 1'b0;
         o_done          <= 1'b0;
         o_err           <= 1'b0;
         bus.o_cmd_ready <= 1'b1;
         bus.o_in_ready  <= 1'b0;
      end else begin
         o_start <= 1'b0;
         o_stop  <= 1'b0;
         o_done  <= 1'b0;
         o_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_fire) begin
                  if (len_ok) begin
                     state           <= LOAD_Q;
                     last_base       <= bus.i_ref_len - LEN_W'(1);
                     last_byte       <= BCNT_W'((bus.i_ref_len - LEN_W'(1)) >> 2);
                     byte_cnt        <= '0;
                     o_busy          <= 1'b1;
                     bus.o_cmd_ready <= 1'b0;
                     bus.o_in_ready  <= 1'b1;
                  end else begin
                     o_err <= 1'b1;
                  end
               end
            end
            LOAD_Q: begin
               if (in_fire) begin
                  o_B[{byte_cnt[QIDX_W-1:0], 3'b000} +: 8] <= bus.i_in_data;
                  if (byte_cnt == BCNT_W'(QBYTES - 1)) begin
                     state    <= LOAD_R;
                     byte_cnt <= '0;
                  end else begin
                     byte_cnt <= byte_cnt + BCNT_W'(1);
                  end
               end
            end
            LOAD_R: begin
               if (in_fire) begin
                  if (byte_cnt == last_byte) begin
                     state          <= STREAM;
                     base_idx       <= '0;
                     o_start        <= 1'b1;
                     bus.o_in_ready <= 1'b0;
                  end else begin
                     byte_cnt <= byte_cnt + BCNT_W'(1);
                  end
               end
            end
            STREAM: begin
               if (base_idx == last_base) begin
                  state     <= FLUSH;
                  flush_cnt <= '0;
               end else begin
                  base_idx <= base_idx + LEN_W'(1);
               end
            end
            FLUSH: begin
               // Stop is registered, so it is raised one count early.
               if (flush_cnt == FLUSH_W'(PE_NUM - 1)) begin
                  state  <= DONE;
                  o_done <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt + FLUSH_W'(1);
                  o_stop    <= (flush_cnt == FLUSH_W'(PE_NUM - 2));
               end
            end
            DONE: begin
               state           <= IDLE;
               o_busy          <= 1'b0;
               bus.o_cmd_ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_feeder.md
Name: seq_feeder

Overview:
- Upstream stage of the 64-PE alignment array.
- Accepts one job: a command, then a byte stream holding the query (B) and reference (A) sequences.
- Packs the query into the array's parallel B bus, buffers the reference, and streams the reference one base per cycle.
- Generates the array's start/stop pulses with the exact flush length, so PE PE_NUM-1 registers its last cell before the array returns to idle.

Parameters:
- PE_NUM, 64, number of PEs; query length in bases; B bus is 2*PE_NUM bits.
- MAX_REF, 256, maximum reference length in bases; must be a multiple of 4.
- LEN_W, 9, width of the reference-length field; must hold MAX_REF.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_cmd_valid  in  1  job command valid
- o_cmd_ready  out  1  high only in IDLE
- i_ref_len  in  LEN_W  reference length in bases, legal range 1..MAX_REF
- i_in_valid  in  1  data byte valid
- o_in_ready  out  1  data byte accepted when high with i_in_valid
- i_in_data  in  8  four bases; base j in bits [2j+1:2j]
- o_start  out  1  one-cycle start pulse to the array
- o_stop  out  1  one-cycle stop pulse to the array
- o_B  out  2*PE_NUM  query bases; base k in bits [2k+1:2k]
- o_A  out  2  reference base for the current cycle
- o_busy  out  1  high from command accept through o_done
- o_done  out  1  one-cycle pulse after the run completes
- o_err  out  1  one-cycle pulse on an illegal command

Behaviour:
- Reset values: state=IDLE, all counters 0, o_B=0, o_A=0, o_start=o_stop=o_done=o_err=0, o_busy=0, o_in_ready=0. Reset asserted mid-job aborts immediately; no start/stop pulse is emitted afterwards.
- Base encoding is A=00, C=01, G=10, T=11.
- States: IDLE, LOAD_Q, LOAD_R, STREAM, FLUSH, DONE.
- IDLE:
  - o_cmd_ready=1.
  - A command handshake with i_ref_len in 1..MAX_REF latches the length and moves to LOAD_Q.
  - A length of 0 or greater than MAX_REF pulses o_err the next cycle, consumes no data and stays in IDLE.
- LOAD_Q:
  - o_in_ready=1.
  - Query byte q (q=0..PE_NUM/4-1) is written to o_B[8q+7:8q] on the handshake.
  - After PE_NUM/4 bytes, go to LOAD_R.
  - o_B is registered and held stable from that point until the next job's LOAD_Q.
- LOAD_R:
  - o_in_ready=1.
  - Byte r writes reference bases 4r..4r+3 into the buffer.
  - ceil(len/4) bytes are consumed; unused bases in the final byte are ignored.
  - Then go to STREAM with o_in_ready=0. The STREAM entry cycle is cycle 0.
- Valid/ready: a byte transfers only when both are high. i_in_valid gaps stall loading with no timeout.
- STREAM:
  - Cycle 0: o_start=1, o_A=ref[0].
  - Cycle k, 1 <= k <= len-1: o_A=ref[k].
  - After cycle len-1, go to FLUSH.
- FLUSH:
  - Cycles len .. len+PE_NUM-1: o_A=00 as padding.
  - o_stop=1 on cycle len+PE_NUM-1 only, which is the last cycle of FLUSH, then go to DONE.
  - The array therefore sees len+PE_NUM cycles from start to stop inclusive.
- DONE: o_done=1 for one cycle, then IDLE.
- o_A=00 in every state except STREAM.
- o_busy=1 in every state except IDLE.
- o_start and o_stop are registered, never both high, and never high outside STREAM/FLUSH.
- len=1 gives start at cycle 0 and stop at cycle PE_NUM.
- Counters: byte counter is LEN_W-2 bits, base index is LEN_W bits, flush counter is clog2(PE_NUM) bits. No wrap occurs within a legal job.
- Back-to-back jobs: a new command is accepted only in IDLE, so there is a minimum of one cycle of DONE between runs.

Decomposition:
- Shared package (alignment package) holds:
  - base encoding constants;
  - PE_NUM;
  - the state encoding;
  - the score width of 14 and the negative-infinity constant 14'b10000000000000 used by the array.
- One natural sub-module, ref_base_buffer:
  - MAX_REF x 2-bit storage with a 4-base write port (byte address) and a 1-base read port (base address).
  - Registered read with 1-cycle latency.
  - The feeder prefetches ref[0] in the last LOAD_R cycle so that o_A is valid in STREAM cycle 0.

Test Plan:
- Reset mid-FLUSH on a len=8 job -> all outputs return to reset values at once, no o_stop or o_done follows, and a new command is accepted afterwards.
- Query bytes 0x1B repeated 16 times, len=4, ref byte 0xE4 -> o_B = 128'h1B..1B; o_A sequence 00,01,10,11 with o_start on the first; 64 padding cycles; o_stop on cycle 67; o_done on cycle 68.
- len=1 -> exactly one non-pad base; o_stop on cycle 64; 1 ref byte consumed.
- len=256 with ref bases equal to index mod 4, plus random i_in_valid gaps -> all 64 ref bytes accepted; o_A matches on cycles 0..255; o_stop on cycle 319.
- i_ref_len=0, then i_ref_len=257 -> o_err pulses each time; o_in_ready stays 0; no o_start.
- len=5 (partial last byte) with upper bits 0xFF in the last ref byte -> only base 4 is streamed, then padding; next job's query load succeeds immediately after o_done.
